// File: rtl/regbus_master.sv
// Peripheral register bus initiator: turns accepted command words into timed
// cs/addr/data/byte-strobe cycles and returns exactly one response per command.
module regbus_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int READ_WAIT     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdWrite,
  input  logic [12:0] cmdAddr,
  input  logic [31:0] cmdData,
  input  logic [3:0]  cmdByteEn,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspData,
  output logic        rspWrite,
  output logic        cs,
  output logic [12:0] addr,
  output logic [31:0] busDataOut,
  input  logic [31:0] busDataIn,
  output logic        wr0,
  output logic        wr1,
  output logic        wr2,
  output logic        wr3
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RDWAIT, RESP} state_t;

  // One shared phase counter; 16 bits covers any sensible timing parameter.
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LAST   = CNT_W'(READ_WAIT - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             cs_reg, cs_next;
  logic [12:0]      addr_reg, addr_next;
  logic [31:0]      wdata_reg, wdata_next;
  logic [3:0]       be_reg, be_next;
  logic [3:0]       wr_reg, wr_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic [31:0]      rsp_data_reg, rsp_data_next;
  logic             rsp_write_reg, rsp_write_next;

  // Next-state and next-output decode; every register holds unless a phase ends.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cs_next        = cs_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    be_next        = be_reg;
    wr_next        = wr_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_write_next = rsp_write_reg;
    case (state_reg)
      IDLE: begin
        if (cmdValid) begin
          cs_next    = 1'b1;
          addr_next  = cmdAddr;
          wdata_next = cmdData;
          be_next    = cmdByteEn;
          cnt_next   = '0;
          state_next = cmdWrite ? SETUP : RDWAIT;
        end
      end
      SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          wr_next    = be_reg;
          cnt_next   = '0;
          state_next = STROBE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STROBE: begin
        if (cnt_reg == STROBE_LAST) begin
          wr_next    = 4'b0000;
          cnt_next   = '0;
          state_next = HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          cs_next        = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_write_next = 1'b1;
          rsp_data_next  = '0;
          cnt_next       = '0;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RDWAIT: begin
        if (cnt_reg == READ_LAST) begin
          cs_next        = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_write_next = 1'b0;
          rsp_data_next  = busDataIn;
          cnt_next       = '0;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        if (rspReady) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered bus/response outputs; reset forces the bus idle at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cs_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      wr_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_write_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cs_reg        <= cs_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      be_reg        <= be_next;
      wr_reg        <= wr_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_write_reg <= rsp_write_next;
    end
  end

  assign cmdReady   = (state_reg == IDLE);
  assign rspValid   = rsp_valid_reg;
  assign rspData    = rsp_data_reg;
  assign rspWrite   = rsp_write_reg;
  assign cs         = cs_reg;
  assign addr       = addr_reg;
  assign busDataOut = wdata_reg;
  assign wr0        = wr_reg[0];
  assign wr1        = wr_reg[1];
  assign wr2        = wr_reg[2];
  assign wr3        = wr_reg[3];

endmodule

// File: tb/tb_regbus_master.sv
// Directed bench for regbus_master with a small behavioural register bank.
module tb_regbus_master;

  logic        clk;
  logic        reset_n;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdWrite;
  logic [12:0] cmdAddr;
  logic [31:0] cmdData;
  logic [3:0]  cmdByteEn;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspData;
  logic        rspWrite;
  logic        cs;
  logic [12:0] addr;
  logic [31:0] busDataOut;
  logic [31:0] busDataIn;
  logic        wr0, wr1, wr2, wr3;
  logic [3:0]  wrv;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int rsp_cnt   = 0;
  int rise_cnt  = 0;

  logic [31:0] mem [0:15];

  regbus_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
    .cmdAddr(cmdAddr), .cmdData(cmdData), .cmdByteEn(cmdByteEn),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspWrite(rspWrite),
    .cs(cs), .addr(addr), .busDataOut(busDataOut), .busDataIn(busDataIn),
    .wr0(wr0), .wr1(wr1), .wr2(wr2), .wr3(wr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign wrv       = {wr3, wr2, wr1, wr0};
  assign busDataIn = mem[addr[3:0]];

  // Bank model: each byte lane latches on the falling edge of its strobe while selected.
  always @(negedge wr0) if (cs === 1'b1) mem[addr[3:0]][7:0]   = busDataOut[7:0];
  always @(negedge wr1) if (cs === 1'b1) mem[addr[3:0]][15:8]  = busDataOut[15:8];
  always @(negedge wr2) if (cs === 1'b1) mem[addr[3:0]][23:16] = busDataOut[23:16];
  always @(negedge wr3) if (cs === 1'b1) mem[addr[3:0]][31:24] = busDataOut[31:24];

  // Count any strobe rising edge, and every completed response handshake.
  always @(posedge wr0 or posedge wr1 or posedge wr2 or posedge wr3) rise_cnt <= rise_cnt + 1;
  always @(posedge clk) if (reset_n && rspValid && rspReady) rsp_cnt <= rsp_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one command; returns at the falling edge after the accepting edge E0.
  task automatic issue(input logic w, input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    check("cmd_ready_before", {31'd0, cmdReady}, 32'd1);
    cmdValid  = 1'b1;
    cmdWrite  = w;
    cmdAddr   = a;
    cmdData   = d;
    cmdByteEn = be;
    tick();
    cmdValid  = 1'b0;
  endtask

  task automatic do_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] be);
    int r0;
    r0 = rise_cnt;
    issue(1'b1, a, d, be);
    check("wr_cs_e0", {31'd0, cs}, 32'd1);
    check("wr_addr_e0", {19'd0, addr}, {19'd0, a});
    check("wr_data_e0", busDataOut, d);
    check("wr_strobe_e0", {28'd0, wrv}, 32'd0);
    check("wr_ready_e0", {31'd0, cmdReady}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wr_strobe_high", {28'd0, wrv}, {28'd0, be});
      check("wr_cs_strobe", {31'd0, cs}, 32'd1);
    end
    tick();
    check("wr_strobe_fall", {28'd0, wrv}, 32'd0);
    check("wr_cs_hold", {31'd0, cs}, 32'd1);
    check("wr_addr_hold", {19'd0, addr}, {19'd0, a});
    check("wr_data_hold", busDataOut, d);
    check("wr_rsp_not_yet", {31'd0, rspValid}, 32'd0);
    tick();
    check("wr_cs_fall", {31'd0, cs}, 32'd0);
    check("wr_rsp_valid", {31'd0, rspValid}, 32'd1);
    check("wr_rsp_write", {31'd0, rspWrite}, 32'd1);
    check("wr_rsp_data", rspData, 32'd0);
    tick();
    check("wr_rsp_done", {31'd0, rspValid}, 32'd0);
    check("wr_ready_back", {31'd0, cmdReady}, 32'd1);
    check("wr_rise_count", rise_cnt - r0, (be != 4'd0) ? 32'd1 : 32'd0);
    $display("write addr=0x%04h data=0x%08h be=0x%1h done", a, d, be);
  endtask

  task automatic do_read(input logic [12:0] a, input logic [31:0] exp);
    int r0;
    r0 = rise_cnt;
    issue(1'b0, a, 32'd0, 4'd0);
    check("rd_cs_e0", {31'd0, cs}, 32'd1);
    check("rd_addr_e0", {19'd0, addr}, {19'd0, a});
    check("rd_rsp_e0", {31'd0, rspValid}, 32'd0);
    tick();
    check("rd_cs_e1", {31'd0, cs}, 32'd1);
    check("rd_rsp_e1", {31'd0, rspValid}, 32'd0);
    tick();
    check("rd_rsp_valid", {31'd0, rspValid}, 32'd1);
    check("rd_rsp_data", rspData, exp);
    check("rd_rsp_write", {31'd0, rspWrite}, 32'd0);
    check("rd_cs_fall", {31'd0, cs}, 32'd0);
    tick();
    check("rd_rsp_done", {31'd0, rspValid}, 32'd0);
    check("rd_no_strobe", rise_cnt - r0, 32'd0);
    $display("read addr=0x%04h data=0x%08h", a, exp);
  endtask

  initial begin
    int r0;
    int n0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[8]    = 32'hAAAAAAAA;
    mem[5]    = 32'hDEADBEEF;
    mem[10]   = 32'hCAFEF00D;
    reset_n   = 1'b0;
    cmdValid  = 1'b0;
    cmdWrite  = 1'b0;
    cmdAddr   = '0;
    cmdData   = '0;
    cmdByteEn = '0;
    rspReady  = 1'b1;
    tick();
    tick();
    check("rst_cs", {31'd0, cs}, 32'd0);
    check("rst_wr", {28'd0, wrv}, 32'd0);
    check("rst_rsp_valid", {31'd0, rspValid}, 32'd0);
    check("rst_rsp_data", rspData, 32'd0);
    check("rst_rsp_write", {31'd0, rspWrite}, 32'd0);
    check("rst_addr", {19'd0, addr}, 32'd0);
    check("rst_data_out", busDataOut, 32'd0);
    check("rst_cmd_ready", {31'd0, cmdReady}, 32'd1);
    reset_n = 1'b1;
    tick();
    $display("reset released");

    // Full-word write then read back through the bank model.
    do_write(13'h0004, 32'h0003A5C3, 4'hF);
    check("bank_word", mem[4], 32'h0003A5C3);
    do_read(13'h0004, 32'h0003A5C3);

    // Single byte lane write into a preloaded register.
    do_write(13'h0008, 32'h11223344, 4'h2);
    do_read(13'h0008, 32'hAAAA33AA);

    // Plain read of a preloaded register.
    do_read(13'h0005, 32'hDEADBEEF);

    // Back-pressured response with a second command already waiting.
    rspReady = 1'b0;
    n0 = rsp_cnt;
    issue(1'b0, 13'h0005, 32'd0, 4'd0);
    tick();
    tick();
    cmdValid = 1'b1;
    cmdWrite = 1'b0;
    cmdAddr  = 13'h0008;
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", {31'd0, rspValid}, 32'd1);
      check("bp_rsp_data", rspData, 32'hDEADBEEF);
      check("bp_cmd_ready", {31'd0, cmdReady}, 32'd0);
      tick();
    end
    rspReady = 1'b1;
    tick();
    check("bp_rsp_done", {31'd0, rspValid}, 32'd0);
    check("bp_one_rsp", rsp_cnt - n0, 32'd1);
    check("bp_ready_after", {31'd0, cmdReady}, 32'd1);
    check("bp_cs_idle", {31'd0, cs}, 32'd0);
    tick();
    cmdValid = 1'b0;
    check("bp_next_accept", {31'd0, cs}, 32'd1);
    check("bp_next_addr", {19'd0, addr}, 32'h0008);
    tick();
    tick();
    check("bp_next_data", rspData, 32'hAAAA33AA);
    tick();
    check("bp_two_rsp", rsp_cnt - n0, 32'd2);
    $display("backpressure read addr=0x0005 then read addr=0x0008 done");

    // Reset asserted while the strobes are high.
    n0 = rsp_cnt;
    issue(1'b1, 13'h0009, 32'h55667788, 4'hF);
    tick();
    check("abort_strobe_up", {28'd0, wrv}, 32'hF);
    #1 reset_n = 1'b0;
    #1;
    check("abort_cs", {31'd0, cs}, 32'd0);
    check("abort_wr", {28'd0, wrv}, 32'd0);
    check("abort_rsp_valid", {31'd0, rspValid}, 32'd0);
    check("abort_cmd_ready", {31'd0, cmdReady}, 32'd1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("abort_no_rsp", rsp_cnt - n0, 32'd0);
    check("abort_rsp_idle", {31'd0, rspValid}, 32'd0);
    $display("reset during strobe addr=0x0009 aborted");
    do_read(13'h0005, 32'hDEADBEEF);

    // Write with no byte enables: full timing, no strobe, response still issued.
    r0 = rise_cnt;
    do_write(13'h000A, 32'h12345678, 4'h0);
    check("be0_bank_kept", mem[10], 32'hCAFEF00D);
    check("be0_no_rise", rise_cnt - r0, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
